dmem_copy_engine: RTL and testbench
===================================

# dmem_copy_engine

Word-granular block-copy initiator driving the data-memory port from the bus-master side. On `start` it copies `len` 32-bit words from byte address `src_addr` to `dst_addr` through a synchronous RAM with 1-cycle registered-address read latency. It sits beside the CPU on the data-memory arbiter: it raises `mem_req` and issues an access only in cycles where `mem_gnt` is high. The CPU keeps priority via the arbiter, so the engine tolerates arbitrary grant stalls.

## Interface
- `LEN_W`, default 12: width of the word-count field (up to 2048 words = full dmem).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `src_addr`  in  32  source byte address; must be word-aligned.
- `dst_addr`  in  32  destination byte address; must be word-aligned.
- `len`  in  LEN_W  number of words to copy; 0 is illegal.
- `busy`  out  1  high from the first cycle after an accepted start through the last write.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  parameter error flag; valid with `done`, held until the next accepted start.
- `mem_req`  out  1  engine requests the memory port.
- `mem_gnt`  in  1  arbiter grant; an access takes effect only in a cycle with `mem_req & mem_gnt`.
- `mem_we`  out  1  write enable, meaningful only when granted.
- `mem_a`  out  32  byte address to memory.
- `mem_wd`  out  32  write data.
- `mem_rd`  in  32  read data, valid the cycle after a granted read.

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE → RD on `start` with valid parameters. The engine latches `src_addr`, `dst_addr` and `len` into internal pointers and a remaining-word counter.
- IDLE → DONE on `start` with `src_addr[1:0]!=0`, `dst_addr[1:0]!=0`, or `len==0`. In this case `err` is set and no memory access is made.
- RD: `mem_req=1`, `mem_we=0`, `mem_a=src_ptr`.
  - Stays in RD while `mem_gnt=0`.
  - On grant: `src_ptr+=4`, go to CAP.
- CAP: `mem_req=0`. Latches `mem_rd` into the data buffer, then goes to WR unconditionally. The grant is irrelevant in this state.
- WR: `mem_req=1`, `mem_we=1`, `mem_a=dst_ptr`, `mem_wd=buffer`.
  - Stays in WR while `mem_gnt=0`.
  - On grant: `dst_ptr+=4` and `remaining-=1`. Go to DONE if `remaining` was 1, else go to RD.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Pointers add 4 modulo 2^32, so wrap from 0xFFFFFFFC to 0x00000000. Dmem decodes only `a[12:2]`, so the copy effectively wraps every 8 KiB.
- Overlapping regions: strictly ascending word-by-word copy. With `dst>src`, the copy propagates already-written words; this is the defined behaviour.
- `start` in any state other than IDLE is ignored; latched parameters do not change.
- In IDLE/CAP/DONE: `mem_we=0`, and `mem_a`/`mem_wd` hold their last values.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `err=0`, `mem_req=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0`, internal pointers, counter and buffer all 0.
- Reset asserted mid-copy aborts immediately with no `done` pulse. Words already written stay written.
- Cycle numbering: start is sampled at edge E0, and cycle 1 follows E0.
- With `mem_gnt` held high, word k (0-based) occupies:
  - RD in cycle 1+3k
  - CAP in cycle 2+3k
  - WR in cycle 3+3k
- Completion: `done` in cycle 3N+1. `busy` is high in cycles 1..3N.
- Each grant-low cycle in RD or WR adds exactly one cycle of latency.
- Error path: `done=1` and `err=1` in cycle 1, `busy` stays 0.
- `err` clears on the next accepted `start`.
- `mem_req`, `mem_we`, `mem_a` and `mem_wd` are functions of registered state only, with no combinational path from `mem_gnt`.

## Test plan
- Basic copy: preload dmem[0x100..0x10C] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start src=0x100, dst=0x200, len=4, `mem_gnt=1`.
  - dmem[0x200..0x20C] match the source.
  - `done` pulses in cycle 13; `busy` is high in cycles 1–12; `err=0`.
- Grant stalls: same copy with `mem_gnt` low for 2 cycles in the first RD and 3 cycles in the last WR.
  - Data is still correct; `done` in cycle 18.
  - No write occurs while `mem_gnt=0`.
- Illegal parameters: start with src=0x102; then dst=0x201; then len=0.
  - Each case gives `done=1` and `err=1` in cycle 1, with `mem_req` never asserted.
  - A following valid start clears `err`.
- Start while busy: a second start with different addresses in cycle 5 of a len=4 copy is ignored. Only the first copy happens, and `done` comes at cycle 13.
- Reset mid-operation: assert `reset` in cycle 7 of a len=4 copy.
  - All outputs go to 0 immediately.
  - Only dst words 0 and 1 are written.
  - No `done` pulse occurs; a new start then works normally.
- Address wrap: src=0xFFFFFFF8, len=3.
  - Reads go to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in that order on `mem_a`.
  - Writes land at the correct dst offsets.

Source files
------------

// File: rtl/dmem_copy_engine_if.sv
// Data-memory port bundle between the copy engine (master) and the arbiter/dmem (slave).
interface dmem_copy_engine_if;
  localparam int unsigned DATA_W = 32;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport master (output mem_req, mem_we, mem_a, mem_wd, input mem_gnt, mem_rd);
  modport slave  (input mem_req, mem_we, mem_a, mem_wd, output mem_gnt, mem_rd);
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-granular block copy through the shared data-memory port.
// Each word is read, captured, then written; every access waits for the arbiter grant.
module dmem_copy_engine #(
  parameter int unsigned LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  dmem_copy_engine_if.master   mem
);
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   src_ptr, src_nx;
  logic [ADDR_W-1:0]   dst_ptr, dst_nx;
  logic [LEN_W-1:0]    remaining, rem_nx;
  logic [31:0]         buffer, buf_nx;
  logic                err_nx, busy_nx, done_nx;
  logic                req_nx, we_nx;
  logic [ADDR_W-1:0]   a_nx;
  logic [31:0]         wd_nx;

  // State and datapath registers; every output is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      buffer      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
      mem.mem_a   <= '0;
      mem.mem_wd  <= '0;
    end else begin
      state       <= state_nx;
      src_ptr     <= src_nx;
      dst_ptr     <= dst_nx;
      remaining   <= rem_nx;
      buffer      <= buf_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      err         <= err_nx;
      mem.mem_req <= req_nx;
      mem.mem_we  <= we_nx;
      mem.mem_a   <= a_nx;
      mem.mem_wd  <= wd_nx;
    end
  end

  // Next state, datapath and next-output values
  always_comb begin
    state_nx = state;
    src_nx   = src_ptr;
    dst_nx   = dst_ptr;
    rem_nx   = remaining;
    buf_nx   = buffer;
    err_nx   = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) || (len == '0)) begin
            state_nx = S_DONE;
            err_nx   = 1'b1;
          end else begin
            state_nx = S_RD;
            src_nx   = src_addr;
            dst_nx   = dst_addr;
            rem_nx   = len;
            err_nx   = 1'b0;
          end
        end
      end
      S_RD: begin
        if (mem.mem_gnt) begin
          src_nx   = src_ptr + ADDR_W'(4);
          state_nx = S_CAP;
        end
      end
      S_CAP: begin
        buf_nx   = mem.mem_rd;
        state_nx = S_WR;
      end
      S_WR: begin
        if (mem.mem_gnt) begin
          dst_nx   = dst_ptr + ADDR_W'(4);
          rem_nx   = remaining - LEN_W'(1);
          state_nx = (remaining == LEN_W'(1)) ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it once registered
    req_nx  = (state_nx == S_RD) || (state_nx == S_WR);
    we_nx   = (state_nx == S_WR);
    busy_nx = (state_nx == S_RD) || (state_nx == S_CAP) || (state_nx == S_WR);
    done_nx = (state_nx == S_DONE);
    a_nx    = mem.mem_a;
    wd_nx   = mem.mem_wd;
    if (state_nx == S_RD) begin
      a_nx = src_nx;
    end else if (state_nx == S_WR) begin
      a_nx  = dst_nx;
      wd_nx = buf_nx;
    end
  end
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a grant-controlled 2048-word dmem model.
module tb_dmem_copy_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [11:0] len;
  logic        busy, done, err;

  dmem_copy_engine_if bus();

  dmem_copy_engine #(.LEN_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .mem(bus)
  );

  always #5 clk = ~clk;

  // dmem: 1-cycle read latency, decodes a[12:2]; bench preload port has priority
  logic [31:0] mem [0:2047];
  logic        pl_we;
  logic [10:0] pl_a;
  logic [31:0] pl_d;
  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) mem[bus.mem_a[12:2]] <= bus.mem_wd;
      else            bus.mem_rd <= mem[bus.mem_a[12:2]];
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          done_cyc, busy_bad, wr_cnt;
  logic        req_seen, err_c1, err_done;
  logic [31:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] v);
    pl_we = 1'b1; pl_a = a[12:2]; pl_d = v;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem[a[12:2]];
  endfunction

  // Start a copy at a negedge; cycle c is observed at the negedge inside it
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n,
                     input logic [63:0] lo_mask, input int s2_cyc, input int rst_cyc,
                     input int exp_done);
    done_cyc = -1; busy_bad = 0; wr_cnt = 0; req_seen = 1'b0; err_c1 = 1'bx; err_done = 1'bx;
    rd_q.delete();
    start = 1'b1; src_addr = s; dst_addr = d; len = n; bus.mem_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      bus.mem_gnt = !lo_mask[c];
      start = (c == s2_cyc);
      if (c == s2_cyc) begin src_addr = 32'h500; dst_addr = 32'h600; len = 12'd2; end
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_flags", 32'({busy, done, err, bus.mem_req, bus.mem_we}), 32'h0);
        chk("rst_mid_a", bus.mem_a, 32'h0);
        chk("rst_mid_wd", bus.mem_wd, 32'h0);
        break;
      end
      if (c == 1) err_c1 = err;
      if (busy !== (c < exp_done)) busy_bad++;
      if (bus.mem_req) req_seen = 1'b1;
      if (bus.mem_req && bus.mem_gnt && !bus.mem_we) rd_q.push_back(bus.mem_a);
      if (bus.mem_req && bus.mem_gnt && bus.mem_we) wr_cnt++;
      if (done) begin done_cyc = c; err_done = err; break; end
      @(negedge clk);
    end
    start = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    bus.mem_gnt = 1'b1; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_flags", 32'({busy, done, err, bus.mem_req, bus.mem_we}), 32'h0);
    chk("reset_a", bus.mem_a, 32'h0);
    chk("reset_wd", bus.mem_wd, 32'h0);

    for (int i = 0; i < 2048; i++) put(32'(i) << 2, 32'hA500_0000 | 32'(i));
    put(32'h100, 32'h1111_1111); put(32'h104, 32'h2222_2222);
    put(32'h108, 32'h3333_3333); put(32'h10C, 32'h4444_4444);

    // Basic copy, grant always high
    run(32'h100, 32'h200, 12'd4, 64'h0, -1, -1, 13);
    chk("basic_done_cycle", 32'(done_cyc), 32'd13);
    chk("basic_busy_window", 32'(busy_bad), 32'd0);
    chk("basic_err", 32'(err_done), 32'd0);
    chk("basic_w0", peek(32'h200), 32'h1111_1111);
    chk("basic_w1", peek(32'h204), 32'h2222_2222);
    chk("basic_w2", peek(32'h208), 32'h3333_3333);
    chk("basic_w3", peek(32'h20C), 32'h4444_4444);
    chk("basic_past_end", peek(32'h210), 32'hA500_0084);

    // Illegal parameters: done+err in cycle 1, no memory request
    run(32'h102, 32'h200, 12'd4, 64'h0, -1, -1, 1);
    chk("bad_src_done", 32'(done_cyc), 32'd1);
    chk("bad_src_err", 32'(err_done), 32'd1);
    chk("bad_src_req", 32'(req_seen), 32'd0);
    chk("bad_src_busy", 32'(busy_bad), 32'd0);
    run(32'h100, 32'h201, 12'd4, 64'h0, -1, -1, 1);
    chk("bad_dst_done", 32'(done_cyc), 32'd1);
    chk("bad_dst_err", 32'(err_done), 32'd1);
    chk("bad_dst_req", 32'(req_seen), 32'd0);
    run(32'h100, 32'h200, 12'd0, 64'h0, -1, -1, 1);
    chk("len0_done", 32'(done_cyc), 32'd1);
    chk("len0_err", 32'(err_done), 32'd1);
    chk("len0_req", 32'(req_seen), 32'd0);
    chk("err_held_idle", 32'(err), 32'd1);

    // Valid start clears err; second start in cycle 5 is ignored
    run(32'h100, 32'h700, 12'd4, 64'h0, 5, -1, 13);
    chk("err_cleared", 32'(err_c1), 32'd0);
    chk("busy_start_done", 32'(done_cyc), 32'd13);
    chk("busy_start_w3", peek(32'h70C), 32'h4444_4444);
    chk("busy_start_ignored", peek(32'h600), 32'hA500_0180);

    // Grant low in cycles 1,2 (first RD) and 14..16 (last WR)
    run(32'h100, 32'h400, 12'd4, 64'h1_C006, -1, -1, 18);
    chk("stall_done_cycle", 32'(done_cyc), 32'd18);
    chk("stall_busy_window", 32'(busy_bad), 32'd0);
    chk("stall_write_count", 32'(wr_cnt), 32'd4);
    chk("stall_w0", peek(32'h400), 32'h1111_1111);
    chk("stall_w3", peek(32'h40C), 32'h4444_4444);

    // Reset in cycle 7 aborts after two words
    run(32'h100, 32'h800, 12'd4, 64'h0, -1, 7, 100);
    chk("rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_w0", peek(32'h800), 32'h1111_1111);
    chk("rst_w1", peek(32'h804), 32'h2222_2222);
    chk("rst_w2_untouched", peek(32'h808), 32'hA500_0202);
    chk("rst_w3_untouched", peek(32'h80C), 32'hA500_0203);
    run(32'h100, 32'h900, 12'd4, 64'h0, -1, -1, 13);
    chk("post_rst_done", 32'(done_cyc), 32'd13);
    chk("post_rst_w3", peek(32'h90C), 32'h4444_4444);

    // Source pointer wraps past 0xFFFFFFFC
    put(32'hFFFF_FFF8, 32'hCAFE_0001); put(32'hFFFF_FFFC, 32'hCAFE_0002);
    put(32'h0000_0000, 32'hCAFE_0003);
    run(32'hFFFF_FFF8, 32'hA00, 12'd3, 64'h0, -1, -1, 10);
    chk("wrap_done", 32'(done_cyc), 32'd10);
    chk("wrap_rd_count", 32'(rd_q.size()), 32'd3);
    if (rd_q.size() == 3) begin
      chk("wrap_rd0", rd_q[0], 32'hFFFF_FFF8);
      chk("wrap_rd1", rd_q[1], 32'hFFFF_FFFC);
      chk("wrap_rd2", rd_q[2], 32'h0000_0000);
    end
    chk("wrap_w0", peek(32'hA00), 32'hCAFE_0001);
    chk("wrap_w1", peek(32'hA04), 32'hCAFE_0002);
    chk("wrap_w2", peek(32'hA08), 32'hCAFE_0003);
    chk("wrap_past_end", peek(32'hA0C), 32'hA500_0283);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
